tape_rec: RTL and testbench

TAPE_REC -- requirements
Module: tape_rec

---
 rtl/tape_rec_if.sv | 41 ++++
 rtl/tape_rec.sv | 199 +++++++++++++++++++
 tb/tb_tape_rec.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tape_rec_if.sv
// ----------------------------------------------------------------------------
// tape_rec_if -- signal bundle between a cassette source/controller and the
// tape recorder decoder.
//
//   ce_samp   source -> recorder  sample enable
//   arm       source -> recorder  one-clk pulse, start a recording
//   cass_in   source -> recorder  cassette line, clk-synchronous
//   wr        recorder -> source  one-clk byte write strobe
//   addr      recorder -> source  write address (bytes already stored)
//   data      recorder -> source  decoded byte, valid while wr=1
//   length    recorder -> source  bytes stored in this recording
//   busy      recorder -> source  recording in progress
//   done      recorder -> source  recording finished (level)
//   overflow  recorder -> source  buffer filled (sticky until arm)
//   frame_err recorder -> source  saturating count of rejected bytes
//
// master: the machine/controller side; slave: the recorder.
// ----------------------------------------------------------------------------
interface tape_rec_if;
    logic        ce_samp;
    logic        arm;
    logic        cass_in;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [15:0] length;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [7:0]  frame_err;

    modport master (
        output ce_samp, arm, cass_in,
        input  wr, addr, data, length, busy, done, overflow, frame_err
    );

    modport slave (
        input  ce_samp, arm, cass_in,
        output wr, addr, data, length, busy, done, overflow, frame_err
    );
endinterface

// File: rtl/tape_rec.sv
// ----------------------------------------------------------------------------
// tape_rec -- cassette tape recorder / decoder.
//
// Measures the period of the cassette signal between rising edges (in ce_samp
// ticks), turns each period into a bit (short = 1, long = 0), assembles
// asynchronous-style frames (start 0, 8 data LSB first, stop 1,1) and writes
// each completed byte into an external buffer RAM.
//
// Parameters:
//   THRESH   period (ticks) at or above which a cycle is a 0 bit
//   TIMEOUT  ticks without a rising edge that end a recording
//
// Ports:
//   clk      system clock, posedge
//   reset_n  synchronous active-low reset
//   bus      tape_rec_if.slave (ce_samp/arm/cass_in in; wr/addr/data/length/
//            busy/done/overflow/frame_err out)
//
// Build option:
//   TAPE_REC_FRAMECHK_EN  when defined, a 0 stop bit rejects the byte and
//                         bumps frame_err; otherwise stop bit values are
//                         ignored and frame_err stays 0.
// ----------------------------------------------------------------------------
module tape_rec #(
    parameter int THRESH  = 12,
    parameter int TIMEOUT = 2000
) (
    input logic       clk,
    input logic       reset_n,
    tape_rec_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_HUNT,
        S_DATA,
        S_STOP1,
        S_STOP2,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        prev_q, prev_d;
    logic [11:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] length_q, length_d;
    logic        wr_q, wr_d;
    logic [7:0]  data_q, data_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  ferr_q, ferr_d;

    logic [11:0] cnt_inc;
    logic        rise;
    logic        bit_one;
    logic        in_frame;
    logic        timed_out;
    logic        stop_bad;
    logic [15:0] len_now;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Cycle measurement and decode helpers.
    always_comb begin
        cnt_inc   = (cnt_q == 12'hFFF) ? cnt_q : cnt_q + 12'd1;
        rise      = bus.ce_samp && bus.cass_in && !prev_q;
        // cnt_inc at a rising edge is the number of ticks since the last edge
        bit_one   = (int'(cnt_inc) < THRESH);
        in_frame  = (state_q == S_HUNT) || (state_q == S_DATA) ||
                    (state_q == S_STOP1) || (state_q == S_STOP2);
        timed_out = in_frame && bus.ce_samp && !rise && (int'(cnt_inc) >= TIMEOUT);
        // Length as it will read when a write issued now becomes visible;
        // any write still in flight is already counted.
        len_now   = length_q + {15'd0, wr_q};
`ifdef TAPE_REC_FRAMECHK_EN
        stop_bad  = !bit_one;
`else
        stop_bad  = 1'b0;
`endif
    end

    // Next-state and datapath.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        length_d   = len_now;
        wr_d       = 1'b0;
        data_d     = data_q;
        overflow_d = overflow_q;
        ferr_d     = ferr_q;

        if (bus.ce_samp) begin
            prev_d = bus.cass_in;
            cnt_d  = rise ? 12'd0 : cnt_inc;
        end

        if (timed_out) begin
            // Partial byte is simply abandoned.
            state_d = S_DONE;
        end else if (rise) begin
            case (state_q)
                S_WAIT: state_d = S_HUNT;   // first edge only opens a cycle
                S_HUNT: begin
                    if (!bit_one) begin
                        state_d = S_DATA;
                        idx_d   = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_d = {bit_one, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP1;
                    end
                end
                S_STOP1: begin
                    if (stop_bad) begin
                        state_d = S_HUNT;
                        ferr_d  = sat_inc8(ferr_q);
                    end else begin
                        state_d = S_STOP2;
                    end
                end
                S_STOP2: begin
                    if (stop_bad) begin
                        state_d = S_HUNT;
                        ferr_d  = sat_inc8(ferr_q);
                    end else begin
                        wr_d    = 1'b1;
                        data_d  = shift_q;
                        if (len_now == 16'hFFFF) begin
                            overflow_d = 1'b1;
                            state_d    = S_DONE;
                        end else begin
                            state_d    = S_HUNT;
                        end
                    end
                end
                default: ;
            endcase
        end

        // arm wins over everything above, including a byte completing now.
        if (bus.arm) begin
            state_d    = S_WAIT;
            cnt_d      = 12'd0;
            idx_d      = 3'd0;
            shift_d    = 8'd0;
            length_d   = 16'd0;
            wr_d       = 1'b0;
            overflow_d = 1'b0;
            ferr_d     = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            prev_q     <= 1'b0;
            cnt_q      <= 12'd0;
            idx_q      <= 3'd0;
            shift_q    <= 8'd0;
            length_q   <= 16'd0;
            wr_q       <= 1'b0;
            data_q     <= 8'd0;
            overflow_q <= 1'b0;
            ferr_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            length_q   <= length_d;
            wr_q       <= wr_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
            ferr_q     <= ferr_d;
        end
    end

    // The write strobe is registered; length picks up the write one clk
    // later, so addr (= length) still shows the pre-increment value during wr.
    assign bus.wr        = wr_q;
    assign bus.addr      = length_q;
    assign bus.data      = data_q;
    assign bus.length    = length_q;
    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.overflow  = overflow_q;
    assign bus.frame_err = ferr_q;

endmodule

// File: tb/tb_tape_rec.sv
// ----------------------------------------------------------------------------
// tb_tape_rec -- self-checking bench for tape_rec.
// A driver turns bit lists into cassette cycles (with random ce_samp gaps and,
// in the random section, random cycle lengths) and pushes the bytes that must
// be written into a scoreboard queue; a negedge monitor pops and compares on
// every wr strobe.
// ----------------------------------------------------------------------------
module tb_tape_rec;
    localparam int THRESH  = 12;
    localparam int TIMEOUT = 2000;

    logic clk = 1'b0;
    logic reset_n;

    tape_rec_if bus();

    tape_rec #(.THRESH(THRESH), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    logic [23:0] exp_q[$];     // {addr, data} of each write still expected
    bit          bq[$];        // bit sequence to play as cassette cycles
    bit          jit = 1'b0;   // randomise cycle lengths
    logic [23:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus.wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_wr: got addr 0x%0h data 0x%0h, required no write",
                         bus.addr, bus.data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", {16'd0, bus.addr}, {16'd0, mon_e[23:8]});
                check("wr_data", {24'd0, bus.data}, {24'd0, mon_e[7:0]});
            end
        end
    end

    // All driver tasks are entered and left 1 time unit after a posedge.
    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic c);
        repeat ($urandom_range(0, 1)) begin
            bus.ce_samp = 1'b0;
            clk_step();
        end
        bus.ce_samp = 1'b1;
        bus.cass_in = c;
        clk_step();
        bus.ce_samp = 1'b0;
    endtask

    task automatic cycle(input int len);
        for (int i = 0; i < len; i++) tick(i < (len + 1) / 2);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0);
    endtask

    task automatic push_ones(input int n);
        repeat (n) bq.push_back(1'b1);
    endtask

    task automatic push_byte(input logic [7:0] b, input bit stop2);
        bq.push_back(1'b0);
        for (int i = 0; i < 8; i++) bq.push_back(b[i]);
        bq.push_back(1'b1);
        bq.push_back(stop2);
    endtask

    // Each bit is one cycle; the extra edge at the end closes the last cycle.
    task automatic play(input bit term);
        foreach (bq[i]) begin
            if (bq[i]) cycle(jit ? int'($urandom_range(6, 10)) : 8);
            else       cycle(jit ? int'($urandom_range(14, 20)) : 16);
        end
        bq.delete();
        if (term) begin
            tick(1'b1);
            tick(1'b1);
            tick(1'b0);
        end
    endtask

    task automatic do_arm();
        bus.arm     = 1'b1;
        bus.ce_samp = 1'b1;
        bus.cass_in = 1'b0;
        clk_step();
        bus.arm     = 1'b0;
        bus.ce_samp = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            clk_step();
            n++;
        end
        repeat (2) clk_step();
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp_ferr;
        int exp_len;
        logic [7:0] b;

        reset_n     = 1'b0;
        bus.ce_samp = 1'b0;
        bus.arm     = 1'b0;
        bus.cass_in = 1'b0;
        repeat (3) clk_step();

        // Reset state.
        check("rst_wr",        {31'd0, bus.wr},        0);
        check("rst_addr",      {16'd0, bus.addr},      0);
        check("rst_data",      {24'd0, bus.data},      0);
        check("rst_length",    {16'd0, bus.length},    0);
        check("rst_busy",      {31'd0, bus.busy},      0);
        check("rst_done",      {31'd0, bus.done},      0);
        check("rst_overflow",  {31'd0, bus.overflow},  0);
        check("rst_frame_err", {24'd0, bus.frame_err}, 0);
        reset_n = 1'b1;
        repeat (2) clk_step();
        check("idle_busy", {31'd0, bus.busy}, 0);

        // Leader of four 1s then 0xA5.
        do_arm();
        check("arm_busy", {31'd0, bus.busy}, 1);
        check("arm_done", {31'd0, bus.done}, 0);
        push_ones(4);
        push_byte(8'hA5, 1'b1);
        expect_wr(16'd0, 8'hA5);
        play(1'b1);
        wait_drain("a5_drain");
        check("a5_length", {16'd0, bus.length}, 1);

        // Three bytes back to back, then end by timeout.
        do_arm();
        check("rearm_length", {16'd0, bus.length}, 0);
        push_ones(2);
        push_byte(8'h00, 1'b1);
        push_byte(8'hFF, 1'b1);
        push_byte(8'h3C, 1'b1);
        expect_wr(16'd0, 8'h00);
        expect_wr(16'd1, 8'hFF);
        expect_wr(16'd2, 8'h3C);
        play(1'b1);
        idle(TIMEOUT);
        repeat (2) clk_step();
        wait_drain("three_drain");
        check("three_done",   {31'd0, bus.done},   1);
        check("three_busy",   {31'd0, bus.busy},   0);
        check("three_length", {16'd0, bus.length}, 3);

        // 0x55 with a bad second stop bit, then 0x12.
        do_arm();
        push_ones(2);
        push_byte(8'h55, 1'b0);
        push_byte(8'h12, 1'b1);
`ifdef TAPE_REC_FRAMECHK_EN
        expect_wr(16'd0, 8'h12);
        exp_ferr = 1;
        exp_len  = 1;
`else
        expect_wr(16'd0, 8'h55);
        expect_wr(16'd1, 8'h12);
        exp_ferr = 0;
        exp_len  = 2;
`endif
        play(1'b1);
        wait_drain("stop_drain");
        check("stop_frame_err", {24'd0, bus.frame_err}, exp_ferr);
        check("stop_length",    {16'd0, bus.length},    exp_len);

        // Random recording: random leader, bytes, gaps and cycle lengths.
        jit = 1'b1;
        do_arm();
        n = int'($urandom_range(3, 6));
        push_ones(int'($urandom_range(1, 5)));
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            push_byte(b, 1'b1);
            expect_wr(16'(i), b);
            push_ones(int'($urandom_range(0, 2)));
        end
        play(1'b1);
        idle(TIMEOUT);
        repeat (2) clk_step();
        wait_drain("rand_drain");
        check("rand_done",      {31'd0, bus.done},      1);
        check("rand_length",    {16'd0, bus.length},    n);
        check("rand_frame_err", {24'd0, bus.frame_err}, 0);
        check("rand_overflow",  {31'd0, bus.overflow},  0);
        jit = 1'b0;

        // Reset part-way through a byte, then a clean 0x81.
        do_arm();
        push_ones(2);
        bq.push_back(1'b0);
        bq.push_back(1'b1);
        bq.push_back(1'b0);
        bq.push_back(1'b1);
        bq.push_back(1'b1);
        play(1'b0);
        bus.cass_in = 1'b0;
        reset_n     = 1'b0;
        repeat (2) clk_step();
        check("midrst_length", {16'd0, bus.length}, 0);
        check("midrst_busy",   {31'd0, bus.busy},   0);
        check("midrst_wr",     {31'd0, bus.wr},     0);
        reset_n = 1'b1;
        clk_step();
        do_arm();
        push_ones(2);
        push_byte(8'h81, 1'b1);
        expect_wr(16'd0, 8'h81);
        play(1'b1);
        wait_drain("midrst_drain");
        check("midrst_len_after", {16'd0, bus.length}, 1);

        // arm on the very tick that completes a byte: no write.
        do_arm();
        push_ones(2);
        push_byte(8'h5A, 1'b1);
        play(1'b0);
        bus.arm     = 1'b1;
        bus.ce_samp = 1'b1;
        bus.cass_in = 1'b1;
        clk_step();
        bus.arm     = 1'b0;
        bus.ce_samp = 1'b0;
        tick(1'b0);
        repeat (3) clk_step();
        check("armprio_length", {16'd0, bus.length}, 0);
        check("armprio_busy",   {31'd0, bus.busy},   1);
        push_ones(2);
        push_byte(8'h3C, 1'b1);
        expect_wr(16'd0, 8'h3C);
        play(1'b1);
        wait_drain("armprio_drain");

        // Last buffer slot: length preset to 0xFFFF.
        do_arm();
        force dut.length_q = 16'hFFFF;
        push_ones(1);
        push_byte(8'hC3, 1'b1);
        expect_wr(16'hFFFF, 8'hC3);
        play(1'b1);
        wait_drain("ovf_drain");
        check("ovf_overflow", {31'd0, bus.overflow}, 1);
        check("ovf_done",     {31'd0, bus.done},     1);
        check("ovf_busy",     {31'd0, bus.busy},     0);
        release dut.length_q;
        clk_step();
        do_arm();
        check("ovf_cleared", {31'd0, bus.overflow}, 0);
        check("ovf_rearm",   {16'd0, bus.length},   0);
        check("ovf_rebusy",  {31'd0, bus.busy},     1);

        repeat (4) clk_step();
        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
